// File: rtl/uart_tx.sv
// uart_tx: byte-wide valid/ready write port with a one-entry holding register,
// serialized onto uart_txd as an async frame (8N1 / 8N2 / 8E1 / 8O1).
module uart_tx #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_wr_data,
    input  logic       uart_wr_valid,
    output logic       uart_wr_ready,
    input  logic [1:0] uart_mode,
    output logic       uart_txd
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int TW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    mode_q, mode_d;
    logic          parity_q, parity_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          ready_q, ready_d;
    logic          txd_q, txd_d;
    logic          tick;
    logic          load;

    assign uart_wr_ready = ready_q;
    assign uart_txd      = txd_q;

    // State register: every flop, synchronous reset to an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            mode_q      <= '0;
            parity_q    <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            mode_q      <= mode_d;
            parity_q    <= parity_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            txd_q       <= txd_d;
        end
    end

    // Next state: bit timer, frame sequencing, holding register and frame load.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        mode_d      = mode_q;
        parity_d    = parity_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        load        = 1'b0;
        tick        = (timer_q == LAST_TICK);

        // Timer only runs while a frame is on the line; it sits at 0 in IDLE.
        if (state_q != S_IDLE) begin
            timer_d = tick ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            S_IDLE: load = hold_full_q;
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d    = mode_q[1] ? S_PARITY : S_STOP;
                        stop_idx_d = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (mode_q == 2'b01 && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else if (hold_full_q) begin
                        // Chain straight into the next start bit, no idle cycle.
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame load: mode is captured here so mid-frame changes wait a frame.
        if (load) begin
            state_d     = S_START;
            timer_d     = '0;
            shift_d     = hold_q;
            mode_d      = uart_mode;
            parity_d    = (^hold_q) ^ uart_mode[0];
            hold_full_d = 1'b0;
        end

        // ready_q is low whenever hold is full, so accept never collides with load.
        if (uart_wr_valid && ready_q) begin
            hold_d      = uart_wr_data;
            hold_full_d = 1'b1;
        end
    end

    // Outputs: registered line level from the next state, ready from next fill.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = parity_d;
            default:  txd_d = 1'b1;
        endcase
        ready_d = ~hold_full_d;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: records the line every cycle and compares it against
// frames built from a bit-list model of the frame format.
module tb_uart_tx;
    localparam int CLK_FREQ  = 1100000;
    localparam int BAUD_RATE = 100000;
    localparam int CPB       = CLK_FREQ / BAUD_RATE;  // 11

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] uart_wr_data = 8'h00;
    logic       uart_wr_valid = 1'b0;
    logic       uart_wr_ready;
    logic [1:0] uart_mode = 2'b00;
    logic       uart_txd;

    int vectors = 0;
    int miscompares = 0;

    logic tx_q[$];
    logic rdy_q[$];
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_wr_data (uart_wr_data),
        .uart_wr_valid(uart_wr_valid),
        .uart_wr_ready(uart_wr_ready),
        .uart_mode    (uart_mode),
        .uart_txd     (uart_txd)
    );

    // Sample index k holds the outputs just after clock edge k.
    always @(posedge clk) begin
        #1;
        tx_q.push_back(uart_txd);
        rdy_q.push_back(uart_wr_ready);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: start 0, data LSB first, optional parity, 1 or 2 stop bits.
    function automatic void exp_frame(input logic [7:0] d, input logic [1:0] m);
        int ones = $countones(d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (m == 2'b10) bits.push_back((ones % 2) == 1);
        if (m == 2'b11) bits.push_back((ones % 2) == 0);
        bits.push_back(1'b1);
        if (m == 2'b01) bits.push_back(1'b1);
        foreach (bits[k]) repeat (CPB) exp_q.push_back(bits[k]);
    endfunction

    function automatic void exp_idle(input int n);
        repeat (n) exp_q.push_back(1'b1);
    endfunction

    function automatic int frame_len(input logic [1:0] m);
        return (m == 2'b00 ? 10 : 11) * CPB;
    endfunction

    function automatic int first_diff(input int start);
        if (start < 0) return 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (start + i >= tx_q.size() || tx_q[start+i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic logic got_at(input int k);
        if (k < 0 || k >= tx_q.size()) return 1'bx;
        return tx_q[k];
    endfunction

    // Mid-bit sampling receiver for a frame whose start bit begins at 'start'.
    function automatic logic [7:0] decode(input int start);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            int k = start + (1 + i) * CPB + CPB / 2;
            v[i] = got_at(k);
        end
        return v;
    endfunction

    task automatic wait_until(input int n);
        while (tx_q.size() < n) @(posedge clk);
        #2;
    endtask

    // Present a byte and hold it until ready; returns the sample index of the accept edge.
    task automatic put(input logic [7:0] d, output int acc);
        int budget = 0;
        @(negedge clk);
        uart_wr_valid = 1'b1;
        uart_wr_data  = d;
        while (!uart_wr_ready && budget < 40 * CPB) begin
            @(negedge clk);
            budget++;
        end
        if (!uart_wr_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL put_timeout: ready=%b required 1", uart_wr_ready);
            acc = -1;
            return;
        end
        @(posedge clk);
        #2;
        acc = tx_q.size() - 1;
    endtask

    task automatic drop_valid();
        @(negedge clk);
        uart_wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        int bad_txd = 0, bad_rdy = 0, zeros = 0, s0;
        @(negedge clk);
        rst = 1'b1;
        uart_wr_valid = 1'b1;
        uart_wr_data  = 8'h3C;
        repeat (10) begin
            @(posedge clk);
            #2;
            if (uart_txd !== 1'b1) bad_txd++;
            if (uart_wr_ready !== 1'b0) bad_rdy++;
        end
        vectors++;
        if (bad_txd != 0) begin
            miscompares++;
            $display("FAIL reset_txd: %0d cycles not high, required 0", bad_txd);
        end
        vectors++;
        if (bad_rdy != 0) begin
            miscompares++;
            $display("FAIL reset_ready: %0d cycles not low, required 0", bad_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        uart_wr_valid = 1'b0;
        @(posedge clk);
        #2;
        vectors++;
        if (uart_wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: ready=%b required 1", uart_wr_ready);
        end
        s0 = tx_q.size();
        wait_until(s0 + 3 * CPB * 11);
        for (int k = s0 - 12; k < s0 + 3 * CPB * 11; k++) if (tx_q[k] !== 1'b1) zeros++;
        vectors++;
        if (zeros != 0) begin
            miscompares++;
            $display("FAIL reset_no_frame: %0d low samples, required 0", zeros);
        end
    endtask

    task automatic test_single();
        int acc, d;
        logic [7:0] b;
        logic [1:0] m;
        for (int t = 0; t < 4; t++) begin
            b = (t == 0) ? 8'h55 : 8'($urandom);
            m = (t == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            uart_mode = m;
            put(b, acc);
            drop_valid();
            exp_q.delete();
            exp_idle(1);
            exp_frame(b, m);
            exp_idle(2 * CPB);
            wait_until(acc + exp_q.size());
            if (t == 0) begin
                vectors++;
                if (got_at(acc) !== 1'b1 || got_at(acc + 1) !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_latency: txd@N=%b txd@N+1=%b required 1,0",
                             got_at(acc), got_at(acc + 1));
                end
                vectors++;
                if (acc < 0 || rdy_q[acc] !== 1'b0 || rdy_q[acc+1] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_ready: ready@N=%b ready@N+1=%b required 0,1",
                             (acc < 0) ? 1'bx : rdy_q[acc], (acc < 0) ? 1'bx : rdy_q[acc+1]);
                end
            end
            d = first_diff(acc);
            vectors++;
            if (d != -1) begin
                miscompares++;
                $display("FAIL single_wave byte=%02h mode=%0d: offset %0d txd=%b required %b",
                         b, m, d, got_at(acc + d), exp_q[d]);
            end
            vectors++;
            if (decode(acc + 1) !== b) begin
                miscompares++;
                $display("FAIL single_decode: got %02h required %02h", decode(acc + 1), b);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[4];
        int acc[4];
        int n, f, d, bad;
        logic [1:0] m;
        for (int run = 0; run < 2; run++) begin
            if (run == 0) begin
                n = 3; m = 2'b00;
                b[0] = 8'h00; b[1] = 8'hFF; b[2] = 8'hA5; b[3] = 8'h00;
            end else begin
                n = 4; m = 2'($urandom_range(0, 3));
                for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
            end
            uart_mode = m;
            f = frame_len(m);
            for (int i = 0; i < n; i++) put(b[i], acc[i]);
            drop_valid();
            exp_q.delete();
            for (int i = 0; i < n; i++) exp_frame(b[i], m);
            exp_idle(2 * CPB);
            wait_until(acc[0] + 1 + exp_q.size());
            d = first_diff(acc[0] + 1);
            vectors++;
            if (d != -1) begin
                miscompares++;
                $display("FAIL b2b_wave run=%0d mode=%0d: offset %0d txd=%b required %b",
                         run, m, d, got_at(acc[0] + 1 + d), exp_q[d]);
            end
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (decode(acc[0] + 1 + i * f) !== b[i]) begin
                    miscompares++;
                    $display("FAIL b2b_decode frame %0d: got %02h required %02h",
                             i, decode(acc[0] + 1 + i * f), b[i]);
                end
            end
            for (int i = 1; i < n; i++) begin
                vectors++;
                if (acc[i] != acc[0] + 2 + (i - 1) * f) begin
                    miscompares++;
                    $display("FAIL b2b_accept_edge byte %0d: edge %0d required %0d",
                             i, acc[i] - acc[0], 2 + (i - 1) * f);
                end
            end
            bad = 0;
            for (int k = acc[1]; k <= acc[0] + f; k++)
                if (k < 0 || rdy_q[k] !== 1'b0) bad++;
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL b2b_ready_while_full: %0d cycles ready high, required 0", bad);
            end
        end
    endtask

    task automatic test_parity();
        int acc, d, s;
        logic [7:0] b;
        logic [1:0] m;
        for (int t = 0; t < 6; t++) begin
            b = (t < 2) ? 8'hA7 : 8'($urandom);
            m = (t == 0) ? 2'b10 : (t == 1) ? 2'b11 : 2'($urandom_range(2, 3));
            uart_mode = m;
            put(b, acc);
            drop_valid();
            s = acc + 1;
            exp_q.delete();
            exp_frame(b, m);
            exp_idle(2 * CPB);
            wait_until(s + exp_q.size());
            if (t < 2) begin
                vectors++;
                if (got_at(s + 9 * CPB + CPB / 2) !== ((t == 0) ? 1'b1 : 1'b0)) begin
                    miscompares++;
                    $display("FAIL parity_bit_a7 mode=%0d: got %b required %b",
                             m, got_at(s + 9 * CPB + CPB / 2), (t == 0) ? 1'b1 : 1'b0);
                end
            end
            d = first_diff(s);
            vectors++;
            if (d != -1) begin
                miscompares++;
                $display("FAIL parity_wave byte=%02h mode=%0d: offset %0d txd=%b required %b",
                         b, m, d, got_at(s + d), exp_q[d]);
            end
        end
    endtask

    task automatic test_stop2_latch();
        int acc, acc2, d, s, ones;
        logic [7:0] nb;
        uart_mode = 2'b01;
        put(8'h81, acc);
        drop_valid();
        s = acc + 1;
        wait_until(s + 5 * CPB + CPB / 2);
        @(negedge clk);
        uart_mode = 2'b00;
        nb = 8'($urandom);
        put(nb, acc2);
        drop_valid();
        exp_q.delete();
        exp_frame(8'h81, 2'b01);
        exp_frame(nb, 2'b00);
        exp_idle(2 * CPB);
        wait_until(s + exp_q.size());
        ones = 0;
        for (int k = s + 9 * CPB; k < s + 11 * CPB; k++) if (got_at(k) === 1'b1) ones++;
        vectors++;
        if (ones != 2 * CPB || got_at(s + 11 * CPB) !== 1'b0) begin
            miscompares++;
            $display("FAIL stop2_len: %0d high stop cycles, next start=%b required %0d,0",
                     ones, got_at(s + 11 * CPB), 2 * CPB);
        end
        d = first_diff(s);
        vectors++;
        if (d != -1) begin
            miscompares++;
            $display("FAIL stop2_wave: offset %0d txd=%b required %b", d, got_at(s + d), exp_q[d]);
        end
        vectors++;
        if (decode(s + 11 * CPB) !== nb) begin
            miscompares++;
            $display("FAIL stop2_next_decode: got %02h required %02h", decode(s + 11 * CPB), nb);
        end
    endtask

    task automatic test_midreset();
        int acc, acc2, s, zeros;
        uart_mode = 2'b00;
        put(8'hF0, acc);
        drop_valid();
        put(8'h0F, acc2);
        drop_valid();
        wait_until(acc + 1 + 4 * CPB + CPB / 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        vectors++;
        if (uart_txd !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_txd: txd=%b required 1", uart_txd);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #2;
        vectors++;
        if (uart_wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_ready: ready=%b required 1", uart_wr_ready);
        end
        s = tx_q.size();
        wait_until(s + 3 * 11 * CPB);
        zeros = 0;
        for (int k = s - 2; k < s + 3 * 11 * CPB; k++) if (tx_q[k] !== 1'b1) zeros++;
        vectors++;
        if (zeros != 0) begin
            miscompares++;
            $display("FAIL midreset_discard: %0d low samples after reset, required 0", zeros);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_stop2_latch();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
